// File: rtl/memstore_arb_pkg.sv
// ---------------------------------------------------------------------------
// memstore_arb_pkg
// Shared definitions for the memstore round-robin arbiter:
//   - arb_state_t : arbiter FSM state encoding (IDLE=0, BUSY=1)
//   - clog2()     : constant function used to size grant_id and the watchdog
//   - DEFAULT_TIMEOUT_CYCLES : default watchdog limit in BUSY
// ---------------------------------------------------------------------------
package memstore_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Smallest w with 2**w >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int w = 0; w < 31; w++) begin
      if ((1 << w) < value) result = w + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/memstore_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches i_req starting at i_last+1
// and wrapping around; the first set bit wins.
// Ports:
//   i_req    in  N    request vector
//   i_last   in  IW   index of the previous winner
//   o_onehot out N    one-hot winner (all zero when no request)
//   o_index  out IW   binary winner index (0 when no request)
//   o_valid  out 1    at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_index,
  output logic          o_valid
);

  assign o_valid = |i_req;

  always_comb begin
    logic w_found;
    int   w_cand;
    w_found  = 1'b0;
    w_cand   = 0;
    o_onehot = '0;
    o_index  = '0;
    // Offset 1 first so the previous winner is considered last.
    for (int k = 1; k <= N; k++) begin
      w_cand = (int'(i_last) + k) % N;
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_onehot[w_cand] = 1'b1;
        o_index          = IW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/memstore_rr_arbiter.sv
// ---------------------------------------------------------------------------
// memstore_rr_arbiter
// Shares one memstore write channel between N_REQ level-held requesters with
// round-robin arbitration. One store is outstanding at a time; operands are
// registered on grant and held stable until ms_done.
// Optional watchdog: define MEMSTORE_ARB_TIMEOUT_EN to abort a store that sees
// no ms_done within TIMEOUT_CYCLES BUSY cycles (req_done + req_error pulse).
// Ports:
//   clock, reset            clock, synchronous active-high reset
//   req_start  [N_REQ]      per-requester start, held until req_done
//   req_addr/data/size      packed operands, requester i at slice i
//   req_done   [N_REQ]      completion pulse (combinational from ms_done)
//   req_error  [N_REQ]      watchdog pulse, coincides with req_done
//   ms_start/addr/data/size registered request to the memstore
//   ms_done                 memstore completion
//   busy                    store outstanding
//   grant_id                current or last granted requester
// ---------------------------------------------------------------------------
module memstore_rr_arbiter
  import memstore_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int BITSIZE_data   = 64,
  parameter int BITSIZE_addr   = 32,
  parameter int BITSIZE_size   = 7,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req_start,
  input  logic [N_REQ*BITSIZE_addr-1:0]   req_addr,
  input  logic [N_REQ*BITSIZE_data-1:0]   req_data,
  input  logic [N_REQ*BITSIZE_size-1:0]   req_size,
  output logic [N_REQ-1:0]                req_done,
  output logic [N_REQ-1:0]                req_error,
  output logic                            ms_start,
  output logic [BITSIZE_addr-1:0]         ms_addr,
  output logic [BITSIZE_data-1:0]         ms_data,
  output logic [BITSIZE_size-1:0]         ms_size,
  input  logic                            ms_done,
  output logic                            busy,
  output logic [clog2(N_REQ)-1:0]         grant_id
);

  localparam int GW = clog2(N_REQ);

  // Unpacked views of the per-requester operand slices.
  logic [BITSIZE_addr-1:0] w_addr [N_REQ];
  logic [BITSIZE_data-1:0] w_data [N_REQ];
  logic [BITSIZE_size-1:0] w_size [N_REQ];
  logic [N_REQ-1:0]        w_grant_dec;

  arb_state_t              r_state;
  logic [GW-1:0]           r_last;
  logic [GW-1:0]           r_grant_id;
  logic                    r_ms_start;
  logic                    r_busy;
  logic [BITSIZE_addr-1:0] r_ms_addr;
  logic [BITSIZE_data-1:0] r_ms_data;
  logic [BITSIZE_size-1:0] r_ms_size;

  logic [N_REQ-1:0]        w_pick_onehot;
  logic [GW-1:0]           w_pick_idx;
  logic                    w_pick_valid;
  logic [BITSIZE_addr-1:0] w_sel_addr;
  logic [BITSIZE_data-1:0] w_sel_data;
  logic [BITSIZE_size-1:0] w_sel_size;
  logic                    w_timeout;
  logic                    w_end;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign w_addr[gi]      = req_addr[gi*BITSIZE_addr +: BITSIZE_addr];
      assign w_data[gi]      = req_data[gi*BITSIZE_data +: BITSIZE_data];
      assign w_size[gi]      = req_size[gi*BITSIZE_size +: BITSIZE_size];
      assign w_grant_dec[gi] = (r_grant_id == GW'(gi));
    end
  endgenerate

  rr_pick #(
    .N  (N_REQ),
    .IW (GW)
  ) u_rr_pick (
    .i_req    (req_start),
    .i_last   (r_last),
    .o_onehot (w_pick_onehot),
    .o_index  (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  // AND-OR operand mux driven by the one-hot winner.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_size = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_sel_addr = w_sel_addr | ({BITSIZE_addr{w_pick_onehot[i]}} & w_addr[i]);
      w_sel_data = w_sel_data | ({BITSIZE_data{w_pick_onehot[i]}} & w_data[i]);
      w_sel_size = w_sel_size | ({BITSIZE_size{w_pick_onehot[i]}} & w_size[i]);
    end
  end

`ifdef MEMSTORE_ARB_TIMEOUT_EN
  localparam int CW = clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_wd_cnt;

  // Held at zero in IDLE, so every BUSY period starts counting from 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + CW'(1);
    end
  end

  // A real ms_done in the limit cycle wins over the timeout.
  assign w_timeout = (r_state == ST_BUSY) && (r_wd_cnt == CW'(TIMEOUT_CYCLES)) && !ms_done;
`else
  // No watchdog: a store can only end through ms_done.
  assign w_timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  assign w_end     = ((r_state == ST_BUSY) && ms_done) || w_timeout;
  assign req_done  = w_end     ? w_grant_dec : '0;
  assign req_error = w_timeout ? w_grant_dec : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_last     <= GW'(N_REQ - 1);
      r_grant_id <= '0;
      r_ms_start <= 1'b0;
      r_busy     <= 1'b0;
      r_ms_addr  <= '0;
      r_ms_data  <= '0;
      r_ms_size  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // ms_done seen here is spurious and deliberately ignored.
          if (w_pick_valid) begin
            r_state    <= ST_BUSY;
            r_grant_id <= w_pick_idx;
            r_ms_start <= 1'b1;
            r_busy     <= 1'b1;
            r_ms_addr  <= w_sel_addr;
            r_ms_data  <= w_sel_data;
            r_ms_size  <= w_sel_size;
          end
        end
        ST_BUSY: begin
          // Always passes through IDLE so the served requester can drop start.
          if (w_end) begin
            r_state    <= ST_IDLE;
            r_ms_start <= 1'b0;
            r_busy     <= 1'b0;
            r_last     <= r_grant_id;
          end
        end
      endcase
    end
  end

  assign ms_start = r_ms_start;
  assign ms_addr  = r_ms_addr;
  assign ms_data  = r_ms_data;
  assign ms_size  = r_ms_size;
  assign busy     = r_busy;
  assign grant_id = r_grant_id;

endmodule

// File: tb/tb_memstore_rr_arbiter.sv
module tb_memstore_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = 7;
  localparam int T  = 8;
`ifdef MEMSTORE_ARB_TIMEOUT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_start = '0;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N*SW-1:0]   req_size;
  logic [N-1:0]      req_done;
  logic [N-1:0]      req_error;
  logic              ms_start;
  logic [AW-1:0]     ms_addr;
  logic [DW-1:0]     ms_data;
  logic [SW-1:0]     ms_size;
  logic              ms_done = 1'b0;
  logic              busy;
  logic [1:0]        grant_id;

  logic [AW-1:0] op_addr [N];
  logic [DW-1:0] op_data [N];
  logic [SW-1:0] op_size [N];

  always #5 clock = ~clock;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    req_size = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = op_addr[i];
      req_data[i*DW +: DW] = op_data[i];
      req_size[i*SW +: SW] = op_size[i];
    end
  end

  memstore_rr_arbiter #(
    .N_REQ          (N),
    .BITSIZE_data   (DW),
    .BITSIZE_addr   (AW),
    .BITSIZE_size   (SW),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_start (req_start),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .req_done  (req_done),
    .req_error (req_error),
    .ms_start  (ms_start),
    .ms_addr   (ms_addr),
    .ms_data   (ms_data),
    .ms_size   (ms_size),
    .ms_done   (ms_done),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_total++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // ---------------- reference model + scoreboard queue ----------------
  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] size;
  } exp_t;

  exp_t exp_q[$];
  bit   m_busy = 1'b0;
  int   m_last = N - 1;
  int   m_gid  = 0;
  int   m_cnt  = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_busy = 1'b0;
      m_last = N - 1;
      m_gid  = 0;
      m_cnt  = 0;
    end else if (m_busy) begin
      if (ms_done || (WD && m_cnt == T)) begin
        m_busy = 1'b0;
        m_last = m_gid;
      end else begin
        m_cnt++;
      end
    end else if (req_start != '0) begin
      int  win;
      bit  found;
      exp_t e;
      win = 0;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (!found && req_start[(m_last + k) % N]) begin
          win = (m_last + k) % N;
          found = 1'b1;
        end
      end
      e.id = win; e.addr = op_addr[win]; e.data = op_data[win]; e.size = op_size[win];
      exp_q.push_back(e);
      m_gid  = win;
      m_busy = 1'b1;
      m_cnt  = 0;
    end
  end

  // ---------------- stimulus drivers ----------------
  bit           rand_en  = 1'b0;
  bit           hold_all = 1'b0;
  int           ms_mode  = 3;   // 0: never, 1: random, 2: always, 3: manual
  logic [N-1:0] done_seen = '0;

  always @(posedge clock) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (req_start[i] && done_seen[i] && !hold_all) begin
        req_start[i] = 1'b0;
      end else if (rand_en && !req_start[i] && $urandom_range(0, 3) == 0) begin
        op_addr[i]   = $urandom;
        op_data[i]   = {$urandom, $urandom};
        op_size[i]   = SW'($urandom_range(0, 127));
        req_start[i] = 1'b1;
      end
    end
    case (ms_mode)
      0: ms_done = 1'b0;
      1: ms_done = ($urandom_range(0, 2) == 0);
      2: ms_done = 1'b1;
      default: ;
    endcase
  end

  // ---------------- monitor ----------------
  bit           mon_en = 1'b0;
  logic         prev_ms_start = 1'b0;
  int           grant_log[$];
  int           err_pulses = 0;
  logic [N-1:0] ed, ee;

  always @(negedge clock) begin
    done_seen = req_done;
    if (mon_en) begin
      ed = '0;
      ee = '0;
      if (m_busy && (ms_done || (WD && m_cnt == T))) begin
        ed[m_gid] = 1'b1;
        ee[m_gid] = !ms_done;
      end
      chk("req_done", req_done, ed);
      chk("req_error", req_error, ee);
      chk("busy", busy, m_busy);
      chk("ms_start", ms_start, m_busy);
      chk("grant_id", grant_id, m_gid);
      if (|req_error) err_pulses++;
      if (ms_start && !prev_ms_start) begin
        grant_log.push_back(int'(grant_id));
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_grant: got grant to %0d, required no grant", grant_id);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("grant id=%0d addr=0x%0h data=0x%0h size=%0d", grant_id, ms_addr, ms_data, ms_size);
          chk("grant_winner", grant_id, e.id);
          chk("grant_addr", ms_addr, e.addr);
          chk("grant_data", ms_data, e.data);
          chk("grant_size", ms_size, e.size);
        end
      end
    end
    prev_ms_start = ms_start;
  end

  task automatic do_reset();
    reset = 1'b1;
    req_start = '0;
    ms_done = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Wait (bounded) for ms_start, let lat BUSY cycles pass, then ack once.
  task automatic serve(input int lat);
    int t;
    t = 0;
    while (!ms_start && t < 50) begin
      step();
      t++;
    end
    if (!ms_start) begin
      n_total++;
      n_bad++;
      $display("FAIL serve_wait: ms_start stayed 0, required 1");
    end
    repeat (lat) step();
    ms_done = 1'b1;
    step();
    ms_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int t;
    for (int i = 0; i < N; i++) begin
      op_addr[i] = '0; op_data[i] = '0; op_size[i] = '0;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ms_start", ms_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_req_done", req_done, 0);
    chk("rst_req_error", req_error, 0);
    chk("rst_ms_addr", ms_addr, 0);
    chk("rst_ms_data", ms_data, 0);
    chk("rst_ms_size", ms_size, 0);
    step();
    reset = 1'b0;
    mon_en = 1'b1;

    // Single request, memstore acks after 3 cycles.
    op_addr[0] = 32'h100; op_data[0] = 64'hDEADBEEF; op_size[0] = 7'd64;
    req_start[0] = 1'b1;
    step();
    chk("single_latency", ms_start, 1);
    chk("single_ms_addr", ms_addr, 32'h100);
    repeat (2) step();
    ms_done = 1'b1;
    #1;
    chk("single_done", req_done, 4'b0001);
    step();
    ms_done = 1'b0;
    chk("single_busy_clear", busy, 0);
    repeat (2) step();

    // All four held with zero-wait memstore: expect 0,1,2,3,0.
    do_reset();
    grant_log.delete();
    hold_all = 1'b1;
    ms_mode = 2;
    for (int i = 0; i < N; i++) begin
      op_addr[i] = $urandom; op_data[i] = {$urandom, $urandom}; op_size[i] = SW'(i + 1);
    end
    req_start = 4'b1111;
    t = 0;
    while (grant_log.size() < 5 && t < 40) begin
      step();
      t++;
    end
    req_start = '0;
    hold_all = 1'b0;
    ms_mode = 3;
    ms_done = 1'b0;
    chk("rr_grant_count", grant_log.size(), 5);
    if (grant_log.size() >= 5) begin
      chk("rr_order0", grant_log[0], 0);
      chk("rr_order1", grant_log[1], 1);
      chk("rr_order2", grant_log[2], 2);
      chk("rr_order3", grant_log[3], 3);
      chk("rr_order4", grant_log[4], 0);
    end
    repeat (3) step();

    // 1 in BUSY, 3 arrives: 3 follows 1. Then 1 and 3 together.
    grant_log.delete();
    req_start[1] = 1'b1;
    step();
    req_start[3] = 1'b1;
    serve(2);
    serve(1);
    chk("late_req_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      chk("late_req_first", grant_log[0], 1);
      chk("late_req_second", grant_log[1], 3);
    end
    step();
    req_start[1] = 1'b1;
    req_start[3] = 1'b1;
    serve(1);
    serve(1);
    repeat (2) step();

    // Reset in the middle of BUSY.
    req_start[1] = 1'b1;
    repeat (2) step();
    reset = 1'b1;
    req_start = '0;
    step();
    chk("midrst_ms_start", ms_start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_grant_id", grant_id, 0);
    chk("midrst_req_done", req_done, 0);
    reset = 1'b0;
    grant_log.delete();
    req_start[2] = 1'b1;
    serve(1);
    chk("post_rst_count", grant_log.size(), 1);
    if (grant_log.size() >= 1) chk("post_rst_winner", grant_log[0], 2);
    repeat (2) step();

`ifdef MEMSTORE_ARB_TIMEOUT_EN
    // Memstore never answers: both stores end through the watchdog.
    err_pulses = 0;
    ms_mode = 0;
    req_start[0] = 1'b1;
    req_start[1] = 1'b1;
    step();
    t = 0;
    while ((req_start != '0 || busy) && t < 60) begin
      step();
      t++;
    end
    chk("timeout_drain", {req_start, busy}, 0);
    chk("timeout_errors", err_pulses, 2);
    ms_mode = 3;
    step();
`endif

    // Spurious ms_done while IDLE.
    ms_done = 1'b1;
    repeat (3) begin
      step();
      chk("spurious_busy", busy, 0);
      chk("spurious_done", req_done, 0);
    end
    ms_done = 1'b0;
    step();

    // Randomized traffic with a random-latency memstore.
    rand_en = 1'b1;
    ms_mode = 1;
    repeat (2000) step();
    rand_en = 1'b0;
    t = 0;
    while ((req_start != '0 || busy) && t < 400) begin
      step();
      t++;
    end
    chk("random_drain", {req_start, busy}, 0);
    ms_mode = 0;
    repeat (3) step();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
